if_fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the fetch PC, issues word requests to instruction memory over a
//  req/ack handshake, buffers returned words, and drives the IF/ID pipeline register that feeds decode.

---
 rtl/if_fetch_stage_if.sv | 11 +
 rtl/if_fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bus between the fetch stage (master) and instruction memory (slave).
// The master holds IMemReq and IMemAddr steady until the slave pulses IMemAck with IMemRData.
interface if_fetch_stage_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemRData;

  modport master (output IMemReq, output IMemAddr, input IMemAck, input IMemRData);
  modport slave  (input IMemReq, input IMemAddr, output IMemAck, output IMemRData);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC, one-outstanding memory requests, fetch buffer and IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating BubbleCount/DiscardCount; otherwise both are tied to zero.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned FB_DEPTH  = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   PC_WriteEnable,
  input  logic                   IFIDWriteEnable,
  input  logic                   IFIDFlush,
  input  logic                   Branch,
  input  logic [31:0]            BranchDest,
  input  logic                   Jump,
  input  logic [31:0]            JumpDest,
  if_fetch_stage_if.master       imem,
  output logic [31:0]            Instruction,
  output logic [31:0]            PC_Out,
  output logic                   IFIDValid,
  output logic [31:0]            BubbleCount,
  output logic [31:0]            DiscardCount
);

  localparam int PTR_W = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FB_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      fb_pc    [FB_DEPTH];
  logic [31:0]      fb_instr [FB_DEPTH];

  logic             redirect;
  logic [31:0]      redirect_pc;
  logic             ack;
  logic             accept;
  logic             buf_empty;
  logic             load_head;
  logic             load_bypass;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_next;
  logic             go;
  logic [31:0]      pc_next;

  // A response is only kept when it answers a live request and no redirect lands on it.
  // Requests are issued only while a slot is free after this cycle, so the response always fits.
  always_comb begin
    redirect    = Jump | Branch;
    redirect_pc = Jump ? JumpDest : BranchDest;
    ack         = imem.IMemReq & imem.IMemAck;
    accept      = ack & (state == S_REQ) & ~redirect;
    buf_empty   = (count == '0);
    load_head   = ~IFIDFlush & IFIDWriteEnable & ~buf_empty;
    load_bypass = ~IFIDFlush & IFIDWriteEnable & buf_empty & accept;
    push        = accept & ~load_bypass;
    pop         = load_head;
    if (redirect)
      count_next = '0;
    else
      count_next = count + CNT_W'(push) - CNT_W'(pop);
    go = PC_WriteEnable & (count_next < FULL_CNT);
    if (redirect)
      pc_next = redirect_pc;
    else if (accept)
      pc_next = fetch_pc + 32'd4;
    else
      pc_next = fetch_pc;
  end

  // Fetch FSM with registered request outputs; DISCARD keeps the old request alive until its ack.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      fetch_pc      <= RESET_PC;
      imem.IMemReq  <= 1'b0;
      imem.IMemAddr <= RESET_PC;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
    end else begin
      fetch_pc <= pc_next;
      count    <= count_next;
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
      end
      case (state)
        S_IDLE: begin
          imem.IMemAddr <= pc_next;
          if (go) begin
            state        <= S_REQ;
            imem.IMemReq <= 1'b1;
          end
        end
        S_REQ, S_DISCARD: begin
          if (ack) begin
            imem.IMemAddr <= pc_next;
            state         <= go ? S_REQ : S_IDLE;
            imem.IMemReq  <= go;
          end else if (redirect) begin
            state <= S_DISCARD;
          end
        end
        default: begin
          state        <= S_IDLE;
          imem.IMemReq <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) begin
      fb_pc[tail]    <= fetch_pc;
      fb_instr[tail] <= imem.IMemRData;
    end
  end

  // IF/ID register: flush beats hold, hold beats load, and an empty buffer forwards the ack directly.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Instruction <= NOP_INSTR;
      PC_Out      <= 32'h0;
      IFIDValid   <= 1'b0;
    end else if (IFIDFlush) begin
      Instruction <= NOP_INSTR;
      IFIDValid   <= 1'b0;
    end else if (IFIDWriteEnable) begin
      if (load_head) begin
        Instruction <= fb_instr[head];
        PC_Out      <= fb_pc[head];
        IFIDValid   <= 1'b1;
      end else if (load_bypass) begin
        Instruction <= imem.IMemRData;
        PC_Out      <= fetch_pc;
        IFIDValid   <= 1'b1;
      end else begin
        Instruction <= NOP_INSTR;
        IFIDValid   <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic bubble;
  logic dropped;

  assign bubble  = ~IFIDFlush & IFIDWriteEnable & buf_empty & ~accept;
  assign dropped = ack & ((state == S_DISCARD) | ((state == S_REQ) & redirect));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      BubbleCount  <= 32'h0;
      DiscardCount <= 32'h0;
    end else begin
      if (bubble && BubbleCount != 32'hFFFF_FFFF)
        BubbleCount <= BubbleCount + 32'd1;
      if (dropped && DiscardCount != 32'hFFFF_FFFF)
        DiscardCount <= DiscardCount + 32'd1;
    end
  end
`else
  assign BubbleCount  = 32'h0;
  assign DiscardCount = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a latency-programmable memory responder, and a scoreboard of
// expected {pc,instr} pairs that is compared whenever the IF/ID register loads a real instruction.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef IF_PERF_CNT_EN
  localparam logic [31:0] EXP_DISCARD = 32'd1;
`else
  localparam logic [31:0] EXP_DISCARD = 32'd0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pc_we;
  logic        ifid_we;
  logic        flush;
  logic        branch;
  logic [31:0] branch_dest;
  logic        jump;
  logic [31:0] jump_dest;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        ifid_valid;
  logic [31:0] bubble_count;
  logic [31:0] discard_count;

  int          checks = 0;
  int          fails  = 0;
  int          mem_lat = 0;
  int          wait_cnt = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] ack_log[$];

  if_fetch_stage_if bus ();

  if_fetch_stage dut (
    .Clock          (clk),
    .Reset          (rst_n),
    .PC_WriteEnable (pc_we),
    .IFIDWriteEnable(ifid_we),
    .IFIDFlush      (flush),
    .Branch         (branch),
    .BranchDest     (branch_dest),
    .Jump           (jump),
    .JumpDest       (jump_dest),
    .imem           (bus),
    .Instruction    (instruction),
    .PC_Out         (pc_out),
    .IFIDValid      (ifid_valid),
    .BubbleCount    (bubble_count),
    .DiscardCount   (discard_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic p_we, input logic i_we, input logic fl,
                               input logic br, input logic [31:0] bd,
                               input logic jp, input logic [31:0] jd);
    pc_we       = p_we;
    ifid_we     = i_we;
    flush       = fl;
    branch      = br;
    branch_dest = bd;
    jump        = jp;
    jump_dest   = jd;
  endtask

  task automatic expectFetch(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    exp_q.push_back(e);
  endtask

  task automatic drainQueue(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput(tag, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: acks after mem_lat idle cycles of a held request.
  always @(negedge clk) begin
    bus.IMemAck = 1'b0;
    if (!rst_n) begin
      wait_cnt = 0;
    end else if (bus.IMemReq) begin
      if (wait_cnt == mem_lat) begin
        bus.IMemAck   = 1'b1;
        bus.IMemRData = mem_word(bus.IMemAddr);
        ack_log.push_back(bus.IMemAddr);
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // IF/ID monitor: every real load must match the next expected fetch, bubbles must carry NOP.
  always @(posedge clk) begin
    #1;
    if (rst_n && ifid_we) begin
      if (flush) begin
        checkOutput("flush_valid", 32'(ifid_valid), 32'd0);
        checkOutput("flush_instr", instruction, NOP);
      end else if (ifid_valid) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          fails++;
          $error("[TB] FAIL extra_load: observed pc %h, expected no load", pc_out);
        end
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          checkOutput("load_pc", pc_out, mon_e.pc);
          checkOutput("load_instr", instruction, mon_e.instr);
        end
      end else begin
        checkOutput("bubble_instr", instruction, NOP);
      end
    end
  end

  initial begin
    bus.IMemAck   = 1'b0;
    bus.IMemRData = 32'h0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_req", 32'(bus.IMemReq), 32'd0);
    checkOutput("rst_addr", bus.IMemAddr, 32'h0);
    checkOutput("rst_instr", instruction, NOP);
    checkOutput("rst_pc_out", pc_out, 32'h0);
    checkOutput("rst_valid", 32'(ifid_valid), 32'd0);
    checkOutput("rst_bubble_cnt", bubble_count, 32'h0);
    checkOutput("rst_discard_cnt", discard_count, 32'h0);

    $display("[TB] back-to-back fetches");
    ack_log.delete();
    expectFetch(32'h0); expectFetch(32'h4); expectFetch(32'h8); expectFetch(32'hC);
    rst_n = 1'b1;
    pc_we = 1'b1;
    repeat (4) @(negedge clk);
    pc_we = 1'b0;
    drainQueue("seq_drain");
    checkOutput("seq_ack_count", 32'(ack_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("seq_addr", ack_log[i], 32'(i * 4));

    $display("[TB] IF/ID hold fills buffer");
    expectFetch(32'h10); expectFetch(32'h14); expectFetch(32'h18);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("hold_req_low", 32'(bus.IMemReq), 32'd0);
    checkOutput("hold_valid", 32'(ifid_valid), 32'd0);
    checkOutput("hold_instr", instruction, NOP);
    ifid_we = 1'b1;
    @(negedge clk);
    checkOutput("pop_req_high", 32'(bus.IMemReq), 32'd1);
    checkOutput("pop_addr", bus.IMemAddr, 32'h18);
    pc_we = 1'b0;
    drainQueue("hold_drain");

    $display("[TB] branch while request outstanding");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h10);
    @(negedge clk);
    mem_lat = 3;
    expectFetch(32'h40);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("disc_req_held", 32'(bus.IMemReq), 32'd1);
    checkOutput("disc_addr_held", bus.IMemAddr, 32'h10);
    checkOutput("disc_valid0", 32'(ifid_valid), 32'd0);
    @(negedge clk);
    checkOutput("disc_valid1", 32'(ifid_valid), 32'd0);
    @(negedge clk);
    checkOutput("disc_new_req", 32'(bus.IMemReq), 32'd1);
    checkOutput("disc_new_addr", bus.IMemAddr, 32'h40);
    checkOutput("disc_valid2", 32'(ifid_valid), 32'd0);
    pc_we = 1'b0;
    drainQueue("disc_drain");
    checkOutput("discard_count", discard_count, EXP_DISCARD);

    $display("[TB] jump beats branch");
    mem_lat = 0;
    expectFetch(32'h100);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h100);
    @(negedge clk);
    checkOutput("jmp_req", 32'(bus.IMemReq), 32'd1);
    checkOutput("jmp_addr", bus.IMemAddr, 32'h100);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    drainQueue("jmp_drain");

    $display("[TB] PC wrap");
    expectFetch(32'hFFFF_FFFC); expectFetch(32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("wrap_addr_top", bus.IMemAddr, 32'hFFFF_FFFC);
    @(negedge clk);
    checkOutput("wrap_req", 32'(bus.IMemReq), 32'd1);
    checkOutput("wrap_addr_zero", bus.IMemAddr, 32'h0);
    pc_we = 1'b0;
    drainQueue("wrap_drain");
    checkOutput("wrap_discard_count", discard_count, EXP_DISCARD);

    $display("[TB] reset mid-request");
    mem_lat = 5;
    pc_we = 1'b1;
    @(negedge clk);
    checkOutput("mid_req_high", 32'(bus.IMemReq), 32'd1);
    checkOutput("mid_addr", bus.IMemAddr, 32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_req_low", 32'(bus.IMemReq), 32'd0);
    checkOutput("async_addr", bus.IMemAddr, 32'h0);
    checkOutput("async_instr", instruction, NOP);
    checkOutput("async_pc_out", pc_out, 32'h0);
    checkOutput("async_valid", 32'(ifid_valid), 32'd0);
    checkOutput("async_discard_cnt", discard_count, 32'h0);
    checkOutput("async_bubble_cnt", bubble_count, 32'h0);
    pc_we = 1'b0;
    @(negedge clk);
    mem_lat = 0;
    expectFetch(32'h0);
    rst_n = 1'b1;
    pc_we = 1'b1;
    @(negedge clk);
    checkOutput("refetch_req", 32'(bus.IMemReq), 32'd1);
    checkOutput("refetch_addr", bus.IMemAddr, 32'h0);
    pc_we = 1'b0;
    drainQueue("refetch_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
